// File: rtl/slot_sched_pkg.sv
// Shared types and bitmap helpers for the slot allocation scheduler.
package slot_sched_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_SLOT_W    = $clog2(DEF_NUM_SLOTS);

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_t;

  // Index of the lowest clear bit; 0 when the bitmap is full (callers gate on full).
  function automatic logic [DEF_SLOT_W-1:0] lowest_zero(input logic [DEF_NUM_SLOTS-1:0] bitmap);
    logic [DEF_SLOT_W-1:0] idx;
    idx = '0;
    for (int i = DEF_NUM_SLOTS - 1; i >= 0; i--) begin
      if (!bitmap[i]) idx = DEF_SLOT_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [DEF_SLOT_W:0] popcount(input logic [DEF_NUM_SLOTS-1:0] bitmap);
    logic [DEF_SLOT_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEF_NUM_SLOTS; i++) begin
      cnt = cnt + {{DEF_SLOT_W{1'b0}}, bitmap[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/slot_alloc_scheduler_if.sv
// Request/grant, release and bitmap status bundle between client engines and the scheduler.
// Handshake: req is a level held until the one-cycle gnt pulse; gnt_slot is valid only while
// |gnt; rel_valid is a single-cycle strobe with no back-pressure, answered by rel_err one cycle later.
interface slot_alloc_scheduler_if #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLOTS = 4
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic [SLOT_W-1:0]    gnt_slot;
  logic                 rel_valid;
  logic [SLOT_W-1:0]    rel_slot;
  logic                 rel_err;
  logic [NUM_SLOTS-1:0] occupancy;
  logic [SLOT_W:0]      free_count;
  logic                 full;
  logic                 empty;

  modport master (
    output req, rel_valid, rel_slot,
    input  gnt, gnt_slot, rel_err, occupancy, free_count, full, empty
  );

  modport slave (
    input  req, rel_valid, rel_slot,
    output gnt, gnt_slot, rel_err, occupancy, free_count, full, empty
  );
endinterface

// File: rtl/slot_alloc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             win_valid,
  output logic [N-1:0]     win_onehot,
  output logic [IDX_W-1:0] win_idx
);

  always_comb begin
    int cand;
    win_valid  = 1'b0;
    win_onehot = '0;
    win_idx    = '0;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!win_valid && req[cand]) begin
        win_valid        = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/slot_alloc_scheduler.sv
// Round-robin slot allocator: grants the lowest free slot to one requester every other cycle
// and clears slots on release. Sole writer of the occupancy bitmap.
module slot_alloc_scheduler
  import slot_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int REQ_W     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  slot_alloc_scheduler_if.slave bus,
  output state_t                state_dbg,
  output logic [REQ_W-1:0]      rr_ptr_dbg
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  state_t               state_q, state_d;
  logic [REQ_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_SLOTS-1:0] occupancy_q, occupancy_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SLOT_W-1:0]    gnt_slot_q, gnt_slot_d;
  logic                 rel_err_q, rel_err_d;

  logic                 win_valid;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [REQ_W-1:0]     win_idx;
  logic                 full_w;
  logic                 alloc;
  logic                 rel_in_range;
  logic                 rel_ok;
  logic [SLOT_W-1:0]    free_slot;
  logic [NUM_SLOTS-1:0] set_mask;
  logic [NUM_SLOTS-1:0] clr_mask;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(REQ_W)) u_arb (
    .req        (bus.req),
    .ptr        (rr_ptr_q),
    .win_valid  (win_valid),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  assign full_w       = &occupancy_q;
  assign alloc        = (state_q == IDLE) && win_valid && !full_w;
  assign rel_in_range = 32'(bus.rel_slot) < NUM_SLOTS;
  assign rel_ok       = bus.rel_valid && rel_in_range && occupancy_q[bus.rel_slot];
  // Slot choice looks at pre-edge occupancy, so a slot freed this cycle is never re-granted here.
  assign free_slot    = lowest_zero(occupancy_q);

  always_comb begin
    set_mask    = '0;
    clr_mask    = '0;
    state_d     = IDLE;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    gnt_slot_d  = '0;
    rel_err_d   = bus.rel_valid && !rel_ok;
    if (alloc) begin
      set_mask   = NUM_SLOTS'(1) << free_slot;
      state_d    = GNT;
      gnt_d      = win_onehot;
      gnt_slot_d = free_slot;
      rr_ptr_d   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end
    if (rel_ok) clr_mask = NUM_SLOTS'(1) << bus.rel_slot;
    occupancy_d = (occupancy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      occupancy_q <= '0;
      gnt_q       <= '0;
      gnt_slot_q  <= '0;
      rel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      occupancy_q <= occupancy_d;
      gnt_q       <= gnt_d;
      gnt_slot_q  <= gnt_slot_d;
      rel_err_q   <= rel_err_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_slot   = gnt_slot_q;
  assign bus.rel_err    = rel_err_q;
  assign bus.occupancy  = occupancy_q;
  assign bus.full       = full_w;
  assign bus.empty      = ~|occupancy_q;
  assign bus.free_count = (SLOT_W + 1)'(NUM_SLOTS) - popcount(occupancy_q);
  assign state_dbg      = state_q;
  assign rr_ptr_dbg     = rr_ptr_q;

endmodule
